cpu_datapath: RTL

Register-transfer datapath directly downstream of the CPU control unit; consumes its load/clear/inc strobes, bus select, memory strobes and ALU controls. Holds AR, PC, DR, AC, IR and TR, the 8-bit common bus mux, the ALU with registered result, and the external memory port. Feeds IR back to the control unit for opcode and immediate decode.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/dp_alu.sv | 42 ++++
 rtl/cpu_datapath.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath: default widths, bus source
// and ALU operation encodings used by the control unit and the datapath.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_STA = 3'd5,
    ALU_NOT = 3'd6,
    ALU_LDD = 3'd7
  } alu_op_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU of the CPU datapath: AC/DR operands, mode select,
// result plus carry (SUB carry is the inverted borrow).
module dp_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] dr,
  input  logic [2:0]        mode,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (alu_op_t'(mode))
      ALU_ADD: begin
        sum    = {1'b0, ac} + {1'b0, dr};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      // Two's-complement subtract so the top bit reads as "no borrow".
      ALU_SUB: begin
        sum    = {1'b0, ac} + {1'b0, ~dr} + (DATA_W+1)'(1);
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      ALU_AND: result = ac & dr;
      ALU_OR:  result = ac | dr;
      ALU_XOR: result = ac ^ dr;
      ALU_STA: result = ac;
      ALU_NOT: result = ~ac;
      default: result = dr;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// Register-transfer datapath (AR, PC, DR, AC, IR, TR, common bus, ALU, memory port).
// Optional macro DP_FLAGS_EN adds registered carry/zero flags beside alu_r.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_AR,
  input  logic              load_PC,
  input  logic              load_DR,
  input  logic              load_AC,
  input  logic              load_IR,
  input  logic              load_TR,
  input  logic              clear_AR,
  input  logic              clear_PC,
  input  logic              clear_DR,
  input  logic              clear_AC,
  input  logic              clear_TR,
  input  logic              inc_AR,
  input  logic              inc_PC,
  input  logic              inc_DR,
  input  logic              inc_AC,
  input  logic              inc_TR,
  input  logic              memory_read,
  input  logic              memory_write,
  input  logic [2:0]        bus_selectors,
  input  logic              alu_enable,
  input  logic [2:0]        alu_mode,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] IR_out,
  output logic [DATA_W-1:0] AC_out,
  output logic [ADDR_W-1:0] PC_out,
  output logic              flag_c,
  output logic              flag_z
);

  logic [ADDR_W-1:0] ar, pc;
  logic [DATA_W-1:0] dr, ac, ir, tr, alu_r;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  always_comb begin
    bus = '0;
    case (bus_sel_t'(bus_selectors))
      BUS_NONE: bus = '0;
      BUS_AR:   bus = DATA_W'(ar);
      BUS_PC:   bus = DATA_W'(pc);
      BUS_DR:   bus = dr;
      BUS_AC:   bus = ac;
      BUS_IR:   bus = ir;
      BUS_TR:   bus = tr;
      default:  bus = memory_read ? mem_rdata : '0;
    endcase
  end

  dp_alu #(.DATA_W(DATA_W)) u_alu (
    .ac     (ac),
    .dr     (dr),
    .mode   (alu_mode),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Each register: clear beats load beats inc; all read the pre-edge bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ar    <= '0;
      pc    <= '0;
      dr    <= '0;
      ac    <= '0;
      ir    <= '0;
      tr    <= '0;
      alu_r <= '0;
    end else begin
      if (clear_AR)     ar <= '0;
      else if (load_AR) ar <= bus[ADDR_W-1:0];
      else if (inc_AR)  ar <= ar + ADDR_W'(1);

      if (clear_PC)     pc <= '0;
      else if (load_PC) pc <= bus[ADDR_W-1:0];
      else if (inc_PC)  pc <= pc + ADDR_W'(1);

      if (clear_DR)     dr <= '0;
      else if (load_DR) dr <= bus;
      else if (inc_DR)  dr <= dr + DATA_W'(1);

      if (clear_AC)     ac <= '0;
      else if (load_AC) ac <= alu_r;
      else if (inc_AC)  ac <= ac + DATA_W'(1);

      if (load_IR)      ir <= bus;

      if (clear_TR)     tr <= '0;
      else if (load_TR) tr <= bus;
      else if (inc_TR)  tr <= tr + DATA_W'(1);

      if (alu_enable)   alu_r <= alu_result;
    end
  end

`ifdef DP_FLAGS_EN
  logic flag_c_r, flag_z_r;

  // Carry is only meaningful for ADD/SUB, so other ops leave it untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_c_r <= 1'b0;
      flag_z_r <= 1'b0;
    end else if (alu_enable) begin
      flag_z_r <= (alu_result == '0);
      if (alu_mode == ALU_ADD || alu_mode == ALU_SUB)
        flag_c_r <= alu_carry;
    end
  end

  assign flag_c = flag_c_r;
  assign flag_z = flag_z_r;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
  assign flag_c = 1'b0;
  assign flag_z = 1'b0;
`endif

  assign mem_addr  = ar;
  assign mem_wdata = bus;
  assign mem_we    = memory_write;
  assign IR_out    = ir;
  assign AC_out    = ac;
  assign PC_out    = pc;

endmodule
